dmem_resp: RTL

DMEM_RESP -- requirements
Module: dmem_resp

---
 rtl/rysy_pkg.sv | 42 ++++
 rtl/dmem_lane_fmt.sv | 46 ++++
 rtl/dmem_resp.sv | 130 +++++++++++++
 3 files changed

// File: rtl/rysy_pkg.sv
// rtl/rysy_pkg.sv - shared access-size codes, dmem FSM states and size decode helpers
package rysy_pkg;

   // Access size/sign codes carried on sel_type
   typedef enum logic [2:0] {
      SEL_SB  = 3'd0,
      SEL_SH  = 3'd1,
      SEL_SW  = 3'd2,
      SEL_SBU = 3'd4,
      SEL_SHU = 3'd5
   } sel_type_e;

   // Data-memory responder FSM states
   typedef enum logic [1:0] {
      DMEM_IDLE   = 2'd0,
      DMEM_WAIT   = 2'd1,
      DMEM_ACCESS = 2'd2,
      DMEM_RESP   = 2'd3
   } dmem_state_e;

   // Decoded access width
   typedef enum logic [1:0] {
      SZ_BYTE = 2'd0,
      SZ_HALF = 2'd1,
      SZ_WORD = 2'd2
   } acc_size_e;

   // Any code that is not a byte or half access is treated as a full word
   function automatic acc_size_e sel_size(input logic [2:0] sel);
      case (sel)
         SEL_SB, SEL_SBU: return SZ_BYTE;
         SEL_SH, SEL_SHU: return SZ_HALF;
         default:         return SZ_WORD;
      endcase
   endfunction

   // Only the non-U byte and half codes sign-extend on load
   function automatic logic sel_signed(input logic [2:0] sel);
      return (sel == SEL_SB) || (sel == SEL_SH);
   endfunction

endpackage

// File: rtl/dmem_lane_fmt.sv
// rtl/dmem_lane_fmt.sv - store byte-enable/lane replication and load extraction/extension
module dmem_lane_fmt
   import rysy_pkg::*;
(
   input  logic [2:0]  sel_type,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] wdata,
   input  logic [31:0] rword,
   output logic [3:0]  be,
   output logic [31:0] wlane,
   output logic [31:0] rload
);

   logic       sgn;
   logic [7:0] byte_v;

   assign sgn    = sel_signed(sel_type);
   assign byte_v = rword[{addr_lo, 3'b000} +: 8];

   // Half accesses ignore addr_lo[0] and word accesses ignore both bits, so a
   // misaligned request naturally lands on the enclosing aligned unit.
   always_comb begin
      be    = 4'b0000;
      wlane = 32'h0000_0000;
      rload = 32'h0000_0000;
      case (sel_size(sel_type))
         SZ_BYTE: begin
            be    = 4'b0001 << addr_lo;
            wlane = {4{wdata[7:0]}};
            rload = {{24{sgn & byte_v[7]}}, byte_v};
         end
         SZ_HALF: begin
            be    = addr_lo[1] ? 4'b1100 : 4'b0011;
            wlane = {2{wdata[15:0]}};
            rload = addr_lo[1] ? {{16{sgn & rword[31]}}, rword[31:16]}
                               : {{16{sgn & rword[15]}}, rword[15:0]};
         end
         default: begin
            be    = 4'b1111;
            wlane = wdata;
            rload = rword;
         end
      endcase
   end

endmodule

// File: rtl/dmem_resp.sv
// rtl/dmem_resp.sv - wait-state data memory responder; DMEM_ALIGN_CHECK_EN enables misalignment rejection
module dmem_resp
   import rysy_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int WAIT_CYCLES = 1
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic        we,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic [2:0]  sel_type,
   output logic        ack,
   output logic [31:0] rdata,
   output logic        err,
   output logic        busy
);

   localparam int IDX_W = $clog2(DEPTH_WORDS);

   dmem_state_e      state;
   logic [2:0]       cnt;
   logic             we_q;
   logic [IDX_W+1:0] addr_q;
   logic [31:0]      wdata_q;
   logic [2:0]       sel_q;

   logic [31:0]      mem [DEPTH_WORDS];
   logic [IDX_W-1:0] idx;
   logic [31:0]      rword;
   logic [3:0]       be;
   logic [31:0]      wlane;
   logic [31:0]      rload;
   logic             mis;

   // Address bits above the array size only wrap, so they are never stored
   logic             unused_addr_hi;
   assign unused_addr_hi = ^addr[31:IDX_W+2];

   assign idx   = addr_q[IDX_W+1:2];
   assign rword = mem[idx];

   dmem_lane_fmt u_lane_fmt (
      .sel_type (sel_q),
      .addr_lo  (addr_q[1:0]),
      .wdata    (wdata_q),
      .rword    (rword),
      .be       (be),
      .wlane    (wlane),
      .rload    (rload)
   );

`ifdef DMEM_ALIGN_CHECK_EN
   // Flag half accesses on odd bytes and word accesses off a word boundary
   always_comb begin
      mis = 1'b0;
      case (sel_size(sel_q))
         SZ_HALF: mis = addr_q[0];
         SZ_WORD: mis = (addr_q[1:0] != 2'b00);
         default: mis = 1'b0;
      endcase
   end
`else
   assign mis = 1'b0;
`endif

   // Request sequencing: capture, wait states, access, one-cycle response
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= DMEM_IDLE;
         cnt     <= 3'd0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= 32'h0000_0000;
         sel_q   <= SEL_SW;
         ack     <= 1'b0;
         rdata   <= 32'h0000_0000;
         err     <= 1'b0;
         busy    <= 1'b0;
      end else begin
         case (state)
            DMEM_IDLE: begin
               if (req) begin
                  we_q    <= we;
                  addr_q  <= addr[IDX_W+1:0];
                  wdata_q <= wdata;
                  sel_q   <= sel_type;
                  cnt     <= 3'(WAIT_CYCLES);
                  busy    <= 1'b1;
                  state   <= (WAIT_CYCLES == 0) ? DMEM_ACCESS : DMEM_WAIT;
               end
            end
            DMEM_WAIT: begin
               cnt <= cnt - 3'd1;
               if (cnt <= 3'd1) begin
                  state <= DMEM_ACCESS;
               end
            end
            DMEM_ACCESS: begin
               ack   <= 1'b1;
               err   <= mis;
               rdata <= (we_q || mis) ? 32'h0000_0000 : rload;
               state <= DMEM_RESP;
            end
            default: begin
               ack   <= 1'b0;
               err   <= 1'b0;
               rdata <= 32'h0000_0000;
               busy  <= 1'b0;
               state <= DMEM_IDLE;
            end
         endcase
      end
   end

   // Array write with byte enables; contents are deliberately not reset
   always_ff @(posedge clk) begin
      if (state == DMEM_ACCESS && we_q && !mis) begin
         for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
               mem[idx][8*b +: 8] <= wlane[8*b +: 8];
            end
         end
      end
   end

endmodule
